bk_adder_pipe: RTL
==================

Name: bk_adder_pipe

Overview:
- Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready handshakes on input and output.
- Generalises the fixed 12-bit combinational prefix adder: configurable width, add/sub mode, carry-in, signed overflow flag, and register cuts inside the prefix tree.
- Sits between operand producers and the datapath consumer; sustains one operation per clock, and back-pressure stalls the whole pipe without losing data.

Parameters:
- WIDTH, 12, operand/sum width in bits; any value ≥2, not restricted to powers of two.
- PIPE_STAGES, 2, register stages; legal range 1..NUM_LEVELS, where NUM_LEVELS = 2*ceil(log2(WIDTH))-1 prefix levels.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1 = A-B; 0 = A+B+cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result bits.
- cout  out  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Pre-processing (level 0): b_eff = sub ? ~b : b; c0 = sub ? 1 : cin; g_i = a_i & b_eff_i; p_i = a_i ^ b_eff_i.
- Prefix tree:
  - Up-sweep levels at span 1,2,4,…, then down-sweep levels, giving NUM_LEVELS levels.
  - Carry-in is folded in as generate at position -1.
  - sum_i = p_i ^ c_i; cout = c_WIDTH; ovf = c_WIDTH ^ c_(WIDTH-1).
- Register cuts:
  - Stage k (1..PIPE_STAGES) ends after prefix level round(k*NUM_LEVELS/PIPE_STAGES).
  - The final stage register drives sum/cout/ovf directly; outputs are registered with no combinational path from inputs.
  - Each stage register carries the p vector, the partial g/p group signals and a valid bit.
- Latency and throughput:
  - Latency is exactly PIPE_STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, when out_ready is held high.
  - Throughput is 1 beat/clk.
- Flow control (elastic, per stage):
  - adv_k = ~valid_k | adv_(k+1); the last stage has adv = ~out_valid | out_ready.
  - in_ready = adv_1. This is combinational from out_ready through the valid bits, and in_ready must not depend on in_valid.
  - A stage holds its data while not advancing; bubbles collapse, so a full pipe holds PIPE_STAGES beats.
- Simultaneous events: accept and emit in the same cycle when full and out_ready=1. There is no bubble, and order is strictly FIFO.
- Handshake rule: out_valid stays high with sum/cout/ovf stable until out_ready is sampled high.
- Reset:
  - While rst_n=0 at the clock edge, all valid bits clear and all data registers load 0.
  - out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 during the first cycle after reset.
  - Reset mid-operation discards in-flight beats; there is no partial output.
- Wrap-around: sums are modulo 2^WIDTH; cout and ovf report the excess.

Decomposition:
- Shared package bk_pkg:
  - function num_levels(width);
  - function cut_level(k, stages, width);
  - typedef of the stage payload struct (p, g, pp arrays sized by WIDTH).
- One natural sub-module: bk_prefix_level, one combinational prefix level parametrised by level index and WIDTH. It is instantiated in a generate loop, with a conditional register after cut levels.

Test Plan:
- WIDTH=12, PIPE_STAGES=2:
  - a=0xFFF, b=0x001, cin=0, sub=0 -> sum=0x000, cout=1, ovf=0, out_valid exactly 2 cycles after acceptance.
  - a=0x7FF, b=0x001, sub=0 -> sum=0x800, cout=0, ovf=1.
  - a=0x005, b=0x007, sub=1 -> sum=0xFFE, cout=0, ovf=0; and a=0x800, b=0x001, sub=1 -> sum=0x7FF, cout=1, ovf=1.
- Back-pressure:
  - Stream 5 beats (a=1..5, b=0x010) with out_ready=0 -> exactly 2 beats accepted, then in_ready=0.
  - Raise out_ready -> results 0x011..0x015 in order, no loss or duplication, one per cycle.
- Reset mid-stream: rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 and outputs 0 next cycle; neither beat ever appears.
- Sweep WIDTH∈{2,12,17,32} × PIPE_STAGES∈{1,NUM_LEVELS} with 10k random beats and random in_valid/out_ready -> every result matches a behavioural a±b+cin model, in order.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared helpers for the pipelined Brent-Kung adder: prefix-tree geometry and stage cut placement.
// Latency: none (elaboration-time functions only).
// Backpressure: n/a.
package bk_pkg;

    // Prefix levels over WIDTH nodes (carry-in node plus bits 0..WIDTH-2):
    // clog2 up-sweep levels followed by clog2-1 down-sweep levels.
    function automatic int num_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

    // Prefix level after which pipeline stage k (1-based) registers its payload.
    // Integer form of round(k*NL/stages).
    function automatic int cut_level(input int k, input int stages, input int width);
        int nl;
        nl = num_levels(width);
        return (2 * k * nl + stages) / (2 * stages);
    endfunction

    // Stage number whose register sits after this level, or 0 when the level is not a cut.
    function automatic int stage_of_level(input int level, input int stages, input int width);
        for (int k = 1; k <= stages; k++) begin
            if (cut_level(k, stages, width) == level) begin
                return k;
            end
        end
        return 0;
    endfunction

    // Distance between combined nodes at a level: 1,2,4,... going up, then back down to 1.
    function automatic int level_span(input int level, input int width);
        int l2;
        l2 = $clog2(width);
        if (level <= l2) begin
            return 1 << (level - 1);
        end
        return 1 << (2 * l2 - 1 - level);
    endfunction

    // True when node 'node' merges with node 'node - span' at this level.
    // Up-sweep: nodes whose index+1 is a multiple of 2*span.
    // Down-sweep: nodes sitting half-way between two up-sweep roots, excluding the first block.
    function automatic bit combines(input int node, input int level, input int width);
        int s;
        s = level_span(level, width);
        if (level <= $clog2(width)) begin
            return ((node + 1) % (2 * s)) == 0;
        end
        return (((node + 1) % (2 * s)) == s) && ((node + 1) > (2 * s));
    endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// One combinational Brent-Kung prefix level over WIDTH (g,p) nodes; node 0 is the carry-in.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage owns flow control.
// Ports: g_i/p_i group generate/propagate into the level, g_o/p_o out of it.
module bk_prefix_level
    import bk_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int LEVEL = 1
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);

    localparam int SPAN = level_span(LEVEL, WIDTH);

    for (genvar j = 0; j < WIDTH; j++) begin : g_node
        if (combines(j, LEVEL, WIDTH)) begin : g_op
            // Classic prefix operator: (g,p)_hi o (g,p)_lo.
            assign g_o[j] = g_i[j] | (p_i[j] & g_i[j-SPAN]);
            assign p_o[j] = p_i[j] & p_i[j-SPAN];
        end else begin : g_pass
            assign g_o[j] = g_i[j];
            assign p_o[j] = p_i[j];
        end
    end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with elastic valid/ready stages and registered outputs.
// Latency: PIPE_STAGES cycles from accepted beat to out_valid; one beat per clock sustained.
// Backpressure: each stage holds while its successor is full and stalled; in_ready = stage 1 can advance.
// Ports: clk/rst_n (sync active-low), in_valid/in_ready + a,b,cin,sub operands,
//        out_valid/out_ready + sum,cout,ovf results.
module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NL = num_levels(WIDTH);
    localparam logic [PIPE_STAGES-1:0] ONES = '1;

    // Payload travelling through the tree. Node j of g/pp holds the group signals
    // for bits [j-1 .. -1] as far as the tree has resolved them; node 0 is carry-in.
    // p keeps the per-bit propagates for the final XOR, gm the MSB generate for cout.
    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic             gm;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pp;
    } stage_t;

    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES:0]   vld_up;
    logic [PIPE_STAGES-1:0] adv;

    stage_t nxt [0:NL];

    // ---------------- flow control ----------------
    // Stage k advances unless it and every stage after it are full while the
    // consumer stalls; this is the unrolled form of adv_k = ~vld_k | adv_(k+1).
    always_comb begin
        adv = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            adv[k] = out_ready | ~(&((vld_q >> k) | ~(ONES >> k)));
        end
    end

    assign vld_up    = {vld_q, in_valid};
    assign in_ready  = adv[0];
    assign out_valid = vld_q[PIPE_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= vld_up[k];
                end
            end
        end
    end

    // ---------------- level 0: operand conditioning ----------------
    // Subtraction is A + ~B + 1, so the forced carry-in replaces cin.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p0;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;
    assign p0    = a ^ b_eff;

    // Bits shift up one node so the carry-in can occupy node 0 as a pure generate.
    assign nxt[0] = {p0,
                     a[WIDTH-1] & b_eff[WIDTH-1],
                     a[WIDTH-2:0] & b_eff[WIDTH-2:0], c0,
                     p0[WIDTH-2:0], 1'b0};

    // ---------------- prefix levels with register cuts ----------------
    for (genvar l = 1; l <= NL; l++) begin : g_lvl
        localparam int STG = stage_of_level(l, PIPE_STAGES, WIDTH);

        logic [WIDTH-1:0] g_lv;
        logic [WIDTH-1:0] pp_lv;
        stage_t           lv_o;

        bk_prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (l)
        ) u_level (
            .g_i (nxt[l-1].g),
            .p_i (nxt[l-1].pp),
            .g_o (g_lv),
            .p_o (pp_lv)
        );

        assign lv_o = {nxt[l-1].p, nxt[l-1].gm, g_lv, pp_lv};

        // The last cut is the output register below, so only inner cuts register here.
        if (STG != 0 && l != NL) begin : g_cut
            stage_t st_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    st_q <= '0;
                end else if (adv[STG-1]) begin
                    st_q <= lv_o;
                end
            end

            assign nxt[l] = st_q;
        end else begin : g_thru
            assign nxt[l] = lv_o;
        end
    end

    // ---------------- final stage: sum formation and output register ----------------
    // After the last level node i holds c_i for i = 0..WIDTH-1; c_WIDTH needs one more merge.
    stage_t           fin;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             unused_pp;

    assign fin       = nxt[NL];
    assign unused_pp = ^fin.pp;

    always_comb begin
        sum_d  = fin.p ^ fin.g;
        cout_d = fin.gm | (fin.p[WIDTH-1] & fin.g[WIDTH-1]);
        ovf_d  = cout_d ^ fin.g[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv[PIPE_STAGES-1]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
